// File: rtl/dcache_pkg.sv
// ============================================================
// dcache_pkg: shared state encoding and address helpers for the L1 D-cache
// Rev 1.0
// ============================================================
`default_nettype none

package dcache_pkg;

    localparam int OFF_W  = 5;
    localparam int IDX_W  = 4;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_e;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~((32'd1 << OFF_W) - 32'd1);
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] addr);
        return WORD_W'((addr & 32'h0000_001C) >> 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_sram.sv
// ============================================================
// dcache_sram: tag/valid/dirty/data arrays, async read, single write port
// Rev 1.0
// ============================================================
`default_nettype none

module dcache_sram #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 23,
    parameter int IDX_W     = 4,
    parameter int WSEL_W    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic                 valid_o,
    output logic                 dirty_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic [LINE_BITS-1:0] line_o,
    input  logic                 line_we_i,
    input  logic [TAG_W-1:0]     line_tag_i,
    input  logic [LINE_BITS-1:0] line_data_i,
    input  logic                 word_we_i,
    input  logic [WSEL_W-1:0]    word_sel_i,
    input  logic [31:0]          word_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            data_q[idx_i] <= line_data_i;
            tag_q[idx_i]  <= line_tag_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b00000} +: 32] <= word_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
// ============================================================
// dcache_controller: direct-mapped write-back/write-allocate L1 D-cache FSM
// Rev 1.0
// ============================================================
`default_nettype none

module dcache_controller #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_read_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_BITS-1:0] mem_rdata_i
);

    localparam int IDX_W = $clog2(NUM_LINES);

    import dcache_pkg::*;

    state_e               state_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [31:0]          mem_addr_q;
    logic [LINE_BITS-1:0] mem_wdata_q;
    logic [LINE_BITS-1:0] refill_q;

    logic [TAG_W-1:0]     cpu_tag;
    logic [IDX_W-1:0]     cpu_idx;
    logic [WORD_W-1:0]    cpu_word;
    logic                 line_valid;
    logic                 line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic [LINE_BITS-1:0] line_data;
    logic                 cpu_req;
    logic                 in_idle;
    logic                 hit;
    logic                 miss;

    assign cpu_tag  = cpu_addr_i[31 -: TAG_W];
    assign cpu_idx  = cpu_addr_i[OFF_W +: IDX_W];
    assign cpu_word = addr_word(cpu_addr_i);

    assign cpu_req = cpu_read_i | cpu_write_i;
    assign in_idle = (state_q == IDLE);
    assign hit     = in_idle & cpu_req & line_valid & (line_tag == cpu_tag);
    assign miss    = in_idle & cpu_req & ~hit;

    assign stall_o     = ~in_idle | miss;
    assign cpu_rdata_o = (hit & ~cpu_write_i) ? line_data[{cpu_word, 5'b00000} +: 32] : 32'd0;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // The CPU holds its request through a miss, so cpu_idx also addresses the refill.
    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W),
        .WSEL_W    (WORD_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (cpu_idx),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .line_o      (line_data),
        .line_we_i   (state_q == REFILL),
        .line_tag_i  (cpu_tag),
        .line_data_i (refill_q),
        .word_we_i   (hit & cpu_write_i),
        .word_sel_i  (cpu_word),
        .word_data_i (cpu_wdata_i)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        mem_req_q <= 1'b1;
                        if (line_valid && line_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {line_tag, cpu_idx, {OFF_W{1'b0}}};
                            mem_wdata_q <= line_data;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= line_base(cpu_addr_i);
                        end
                    end
                end
                WRITEBACK: begin
                    // Request stays high straight into the fetch phase.
                    if (mem_ack_i) begin
                        state_q    <= ALLOCATE;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= line_base(cpu_addr_i);
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q   <= REFILL;
                        mem_req_q <= 1'b0;
                    end
                end
                REFILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ALLOCATE && mem_ack_i) begin
            refill_q <= mem_rdata_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================
// tb_dcache_controller: randomized bench against a transparent-memory cache model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_dcache_controller;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
    } tx_t;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_read_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [255:0] mem_rdata_i;

    int n_vec;
    int n_err;
    int lat_w;
    int lat_r;

    // Reference state: which line each index holds, plus a flat architectural memory.
    bit           ref_valid [16];
    bit           ref_dirty [16];
    logic [22:0]  ref_tag   [16];
    logic [255:0] mem_lines [int unsigned];
    logic [31:0]  arch      [int unsigned];
    tx_t          txlog     [$];

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_read_i  (cpu_read_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        if (mem_lines.exists(la >> 5)) return mem_lines[la >> 5];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [255:0] l;
        if (arch.exists(a >> 2)) return arch[a >> 2];
        l = line_of({a[31:5], 5'b0});
        return l[a[4:2]*32 +: 32];
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        arch.delete();
    endfunction

    // Off-chip memory: acks in the L-th cycle of each request phase.
    initial begin : mem_model
        int          cnt;
        bit          prev_req;
        logic        prev_we;
        logic [31:0] prev_addr;
        cnt = 0; prev_req = 0; prev_we = 0; prev_addr = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (rst_i !== 1'b1) begin
                cnt = 0;
                prev_req = 0;
            end else if (mem_req_o === 1'b1) begin
                if (!prev_req || mem_we_o !== prev_we || mem_addr_o !== prev_addr) cnt = 1;
                else cnt++;
                prev_req  = 1;
                prev_we   = mem_we_o;
                prev_addr = mem_addr_o;
                if (cnt == (mem_we_o ? lat_w : lat_r)) begin
                    mem_ack_i = 1'b1;
                    txlog.push_back('{we: mem_we_o, addr: mem_addr_o, data: mem_wdata_o});
                    if (mem_we_o) mem_lines[mem_addr_o >> 5] = mem_wdata_o;
                    else          mem_rdata_i = line_of(mem_addr_o);
                end
            end else begin
                prev_req = 0;
            end
        end
    end

    // One CPU access from issue to completion; starts and ends just after a rising edge.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int           idx, n_stall, req_cyc, log0, exp_stall, exp_req, exp_tx;
        bit           hit, wb;
        logic [22:0]  tg;
        logic [31:0]  exp_rd, vaddr;
        logic [255:0] vline;
        tx_t          t;
        idx   = int'(a[8:5]);
        tg    = a[31:9];
        hit   = ref_valid[idx] && (ref_tag[idx] == tg);
        wb    = !hit && ref_valid[idx] && ref_dirty[idx];
        vaddr = {ref_tag[idx], a[8:5], 5'b0};
        for (int w = 0; w < 8; w++) vline[w*32 +: 32] = exp_word(vaddr + 32'(w * 4));
        exp_stall = hit ? 0 : (wb ? lat_w + lat_r + 2 : lat_r + 2);
        exp_req   = hit ? 0 : (wb ? lat_w + lat_r : lat_r);
        exp_tx    = hit ? 0 : (wb ? 2 : 1);
        exp_rd    = (rd && !wr) ? exp_word(a) : 32'd0;
        log0      = txlog.size();

        cpu_read_i = rd; cpu_write_i = wr; cpu_addr_i = a; cpu_wdata_i = wd;
        n_stall = 0; req_cyc = 0;
        @(negedge clk_i);
        if (mem_req_o === 1'b1) req_cyc++;
        while (stall_o !== 1'b0 && n_stall < 300) begin
            n_stall++;
            @(negedge clk_i);
            if (mem_req_o === 1'b1) req_cyc++;
        end

        n_vec++;
        if (n_stall !== exp_stall) begin
            n_err++;
            $display("FAIL stall_cycles @%h: got %0d expected %0d", a, n_stall, exp_stall);
        end
        n_vec++;
        if (req_cyc !== exp_req) begin
            n_err++;
            $display("FAIL req_cycles @%h: got %0d expected %0d", a, req_cyc, exp_req);
        end
        n_vec++;
        if (cpu_rdata_o !== exp_rd) begin
            n_err++;
            $display("FAIL rdata @%h: got %h expected %h", a, cpu_rdata_o, exp_rd);
        end
        n_vec++;
        if (txlog.size() - log0 != exp_tx) begin
            n_err++;
            $display("FAIL tx_count @%h: got %0d expected %0d", a, txlog.size() - log0, exp_tx);
        end else begin
            if (wb) begin
                n_vec++;
                if (txlog[log0].we !== 1'b1 || txlog[log0].addr !== vaddr) begin
                    n_err++;
                    $display("FAIL wb_addr @%h: got we=%b addr=%h expected we=1 addr=%h",
                             a, txlog[log0].we, txlog[log0].addr, vaddr);
                end
                n_vec++;
                if (txlog[log0].data !== vline) begin
                    n_err++;
                    $display("FAIL wb_data @%h: got %h expected %h", a, txlog[log0].data, vline);
                end
            end
            if (!hit) begin
                t = txlog[log0 + (wb ? 1 : 0)];
                n_vec++;
                if (t.we !== 1'b0 || t.addr !== {a[31:5], 5'b0}) begin
                    n_err++;
                    $display("FAIL fetch_addr @%h: got we=%b addr=%h expected we=0 addr=%h",
                             a, t.we, t.addr, {a[31:5], 5'b0});
                end
            end
        end

        if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_dirty[idx] = 1'b1;
            arch[a >> 2]   = wd;
        end
        @(posedge clk_i); #1;
        cpu_read_i = 1'b0; cpu_write_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; cpu_read_i = 1'b0; cpu_write_i = 1'b0;
        cpu_addr_i = '0; cpu_wdata_i = '0;
        reset_model();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        n_vec++; if (stall_o !== 1'b0)     begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        n_vec++; if (mem_req_o !== 1'b0)   begin n_err++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
        n_vec++; if (mem_we_o !== 1'b0)    begin n_err++; $display("FAIL reset_we: got %b expected 0", mem_we_o); end
        n_vec++; if (mem_addr_o !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
        n_vec++; if (mem_wdata_o !== '0)   begin n_err++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata_o); end
        n_vec++; if (cpu_rdata_o !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_cold_read();
        logic [255:0] l;
        l = line_of(32'h0000_0100);
        l[63:32] = 32'hDEAD_BEEF;
        mem_lines[32'h0000_0100 >> 5] = l;
        lat_r = 4;
        do_access(1'b1, 1'b0, 32'h0000_0104, 32'd0);
    endtask

    task automatic test_hit_read();
        do_access(1'b1, 1'b0, 32'h0000_0108, 32'd0);
    endtask

    task automatic test_write_hit();
        int n0;
        n0 = txlog.size();
        do_access(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678);
        do_access(1'b1, 1'b0, 32'h0000_0104, 32'd0);
        n_vec++;
        if (txlog.size() != n0) begin
            n_err++;
            $display("FAIL write_hit_traffic: got %0d transfers expected 0", txlog.size() - n0);
        end
    endtask

    task automatic test_dirty_evict();
        int n0;
        n0 = txlog.size();
        lat_w = 3; lat_r = 2;
        do_access(1'b1, 1'b0, 32'h0000_0304, 32'd0);
        n_vec++;
        if (txlog.size() < n0 + 1 || txlog[n0].data[63:32] !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL evict_word1: got %h expected 12345678",
                     (txlog.size() > n0) ? txlog[n0].data[63:32] : 32'hXXXX_XXXX);
        end
    endtask

    task automatic test_write_miss();
        int n0;
        lat_r = 3; lat_w = 2;
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
        do_access(1'b1, 1'b0, 32'h0000_0020, 32'd0);
        n0 = txlog.size();
        do_access(1'b1, 1'b0, 32'h0000_0220, 32'd0);
        n_vec++;
        if (txlog.size() < n0 + 1 || txlog[n0].we !== 1'b1 || txlog[n0].data[31:0] !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL write_miss_dirty: got %h expected a5a5a5a5 written back",
                     (txlog.size() > n0) ? txlog[n0].data[31:0] : 32'hXXXX_XXXX);
        end
    endtask

    task automatic test_reset_mid_miss();
        lat_r = 4;
        cpu_read_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0440;
        @(negedge clk_i);
        n_vec++;
        if (stall_o !== 1'b1) begin n_err++; $display("FAIL midmiss_detect: got stall %b expected 1", stall_o); end
        @(negedge clk_i);
        n_vec++;
        if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 32'h0000_0440}) begin
            n_err++;
            $display("FAIL midmiss_fetch: got req=%b we=%b addr=%h expected req=1 we=0 addr=00000440",
                     mem_req_o, mem_we_o, mem_addr_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; cpu_read_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        reset_model();
        @(negedge clk_i);
        n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL midmiss_req: got %b expected 0", mem_req_o); end
        n_vec++; if (stall_o !== 1'b0)   begin n_err++; $display("FAIL midmiss_stall: got %b expected 0", stall_o); end
        @(posedge clk_i); #1;
        do_access(1'b1, 1'b0, 32'h0000_0304, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          kind;
        for (int i = 0; i < 150; i++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            lat_w = int'($urandom_range(1, 4));
            lat_r = int'($urandom_range(1, 4));
            kind  = int'($urandom_range(0, 3));
            if (kind < 2)       do_access(1'b1, 1'b0, a, 32'($urandom));
            else if (kind == 2) do_access(1'b0, 1'b1, a, 32'($urandom));
            else                do_access(1'b1, 1'b1, a, 32'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk_i);
                n_vec++;
                if (stall_o !== 1'b0 || cpu_rdata_o !== 32'd0) begin
                    n_err++;
                    $display("FAIL idle_outputs: got stall=%b rdata=%h expected 0/0", stall_o, cpu_rdata_o);
                end
                @(posedge clk_i); #1;
            end
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : main
        n_vec = 0; n_err = 0;
        lat_w = 2; lat_r = 2;
        test_reset();
        test_cold_read();
        test_hit_read();
        test_write_hit();
        test_dirty_evict();
        test_write_miss();
        test_reset_mid_miss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache controller for the 5-stage pipelined CPU. It sits between the MEM stage (the data-memory request from the EX/MEM latch) and a multi-cycle off-chip memory with a req/ack handshake. It holds the pipeline via `stall_o` while misses are serviced.

## Interface
Parameters:
- `NUM_LINES`, 16: cache lines; power of two. Index width `IDX_W = log2(NUM_LINES)`.
- `LINE_BITS`, 256: line size (32 bytes, 8 words). Offset width `OFF_W = 5`.
- `TAG_W`, 23: `32 - IDX_W - OFF_W`.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_i` in 1: reset, synchronous, active-low.
- `cpu_read_i` in 1: MEM-stage load request.
- `cpu_write_i` in 1: MEM-stage store request.
- `cpu_addr_i` in 32: byte address; `[1:0]` ignored (word access only).
- `cpu_wdata_i` in 32: store data.
- `cpu_rdata_o` out 32: load data.
- `stall_o` out 1: freezes PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = line write-back, 0 = line fetch.
- `mem_addr_o` out 32: line-aligned address (`[4:0]` = 0).
- `mem_wdata_o` out LINE_BITS: victim line.
- `mem_ack_i` in 1: one-cycle completion pulse.
- `mem_rdata_i` in LINE_BITS: fetched line; valid in the `mem_ack_i` cycle.

## Operation
- Address split: tag `[31:9]`, index `[8:5]`, word select `[4:2]`.
- Hit = request ∧ `valid[idx]` ∧ `tag[idx] == addr tag`.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE, no request: idle; `stall_o` = 0.
- IDLE, hit:
  - Read: `cpu_rdata_o` = selected word, combinationally.
  - Write: the selected word is updated and `dirty[idx]` is set at the clock edge.
  - `stall_o` = 0.
- IDLE, miss: `stall_o` = 1.
  - Next state is WRITEBACK if `valid ∧ dirty` on the victim, otherwise ALLOCATE.
- WRITEBACK: `mem_req_o` = 1, `mem_we_o` = 1, `mem_addr_o` = {victim tag, idx, 5'b0}, `mem_wdata_o` = victim line. On ack, go to ALLOCATE.
- ALLOCATE: `mem_req_o` = 1, `mem_we_o` = 0, `mem_addr_o` = {cpu tag, idx, 5'b0}. On ack, capture `mem_rdata_i` into the refill buffer and go to REFILL.
- REFILL: write the buffer into the line and set valid = 1, dirty = 0, tag = cpu tag. Go to IDLE.
  - In IDLE the request re-evaluates as a hit and completes (a store then sets dirty).
- The CPU holds `cpu_*` stable while `stall_o` = 1.
- `cpu_read_i` and `cpu_write_i` both high: treated as a write.
- `cpu_rdata_o` = 0 whenever it is not an IDLE read hit.

## Timing
- Reset (edge with `rst_i` = 0):
  - State goes to IDLE.
  - All valid and dirty bits are cleared.
  - `stall_o`, `mem_req_o`, `mem_we_o` = 0; `mem_addr_o`, `mem_wdata_o` = 0.
  - Data and tag arrays are not reset.
- Reset mid-miss: the outstanding request is abandoned and `mem_req_o` is 0 from the next cycle. Memory shares `rst_i`.
- Hit latency: 0 extra cycles.
- Handshake:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` are registered and stable from the first cycle of the state until the ack cycle inclusive.
  - `mem_req_o` falls on the edge after ack.
  - Ack outside a request is ignored. Ack latency is at least 1 cycle after `req` rises.
- Clean miss with memory latency L (ack in the L-th ALLOCATE cycle): `stall_o` is high for L+2 cycles (miss cycle, L ALLOCATE cycles, REFILL). The access completes in the following cycle.
- Dirty miss with latencies Lw, Lr: `stall_o` is high for Lw+Lr+2 cycles.
- `stall_o` is combinational in IDLE (miss detect) and forced high in every other state.

## Structure
- Package `dcache_pkg`:
  - State enum {IDLE, WRITEBACK, ALLOCATE, REFILL}.
  - `OFF_W`, `IDX_W`, `TAG_W` constants.
  - Address-field extraction functions.
- Sub-module `dcache_sram` holds the tag, valid, dirty and data arrays.
  - Asynchronous read.
  - One synchronous write port with a full-line write or single-word write plus a dirty-set.
  - Valid/dirty clear on reset.
- The FSM, hit compare and word mux live in `dcache_controller`.

## Test plan
- Cold read 0x0000_0104, memory L = 4, line word1 = 0xDEAD_BEEF:
  - `stall_o` is high for 6 cycles.
  - One fetch at `mem_addr_o` = 0x0000_0100, `mem_we_o` = 0.
  - Then `cpu_rdata_o` = 0xDEAD_BEEF with `stall_o` = 0.
- Read 0x0000_0108 right after:
  - Hit.
  - No `mem_req_o` and no stall.
- Write hit 0x0000_0104 ← 0x1234_5678, then read the same address:
  - Read returns 0x1234_5678.
  - `dirty[8]` = 1 and no memory traffic.
- Read 0x0000_0304 (same index 8, new tag), which evicts the dirty line:
  - First a write-back at 0x0000_0100 with word1 = 0x1234_5678 in `mem_wdata_o`.
  - Then a fetch at 0x0000_0300.
  - `stall_o` is high for Lw+Lr+2 cycles.
- Write miss 0x0000_0020 ← 0xA5A5_A5A5:
  - Fetch at 0x0000_0020.
  - Then the word is written and the line is dirty.
  - A readback returns 0xA5A5_A5A5.
- Assert `rst_i` = 0 in the 2nd ALLOCATE cycle:
  - `mem_req_o` and `stall_o` are 0 the next cycle.
  - A prior hit address now misses (valid cleared).
